// File: rtl/fast_iter_sequencer_if.sv
// Handshake bundle between the iteration sequencer and its host / fast controller.
// master drives requests and controller status; slave is the sequencer itself.
interface fast_iter_sequencer_if;
  logic       start;
  logic       fast_busy;
  logic       converged;
  logic       go_fast;
  logic [7:0] iter_cnt;
  logic       seq_busy;
  logic       done;
  logic       conv_ok;
  logic       timeout_err;

  modport master (
    output start,
    output fast_busy,
    output converged,
    input  go_fast,
    input  iter_cnt,
    input  seq_busy,
    input  done,
    input  conv_ok,
    input  timeout_err
  );

  modport slave (
    input  start,
    input  fast_busy,
    input  converged,
    output go_fast,
    output iter_cnt,
    output seq_busy,
    output done,
    output conv_ok,
    output timeout_err
  );
endinterface

// File: rtl/fast_iter_sequencer.sv
// Iteration sequencer: repeatedly releases a fast controller from reset, waits for it
// to finish, and stops on convergence, iteration limit or run timeout.
module fast_iter_sequencer #(
  parameter logic [7:0] GAP      = 8'd2,
  parameter logic [7:0] MAX_ITER = 8'd32,
  parameter logic [7:0] TIMEOUT  = 8'd200
) (
  input logic                  clk_fast,
  input logic                  rst_fast,
  fast_iter_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    EVAL = 3'd3,
    FIN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] gap_cnt;
  logic [7:0] gap_nx;
  logic [7:0] run_cnt;
  logic [7:0] run_nx;
  logic [7:0] iter_q;
  logic [7:0] iter_nx;
  logic       go_q;
  logic       go_nx;
  logic       sbusy_q;
  logic       sbusy_nx;
  logic       done_q;
  logic       done_nx;
  logic       conv_q;
  logic       conv_nx;
  logic       terr_q;
  logic       terr_nx;

  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    run_nx   = run_cnt;
    iter_nx  = iter_q;
    go_nx    = go_q;
    conv_nx  = conv_q;
    terr_nx  = terr_q;

    case (state)
      IDLE: begin
        go_nx = 1'b0;
        if (bus.start) begin
          iter_nx  = '0;
          conv_nx  = 1'b0;
          terr_nx  = 1'b0;
          gap_nx   = '0;
          state_nx = ARM;
        end
      end

      ARM: begin
        go_nx = 1'b0;
        if (gap_cnt == GAP) begin
          go_nx    = 1'b1;
          run_nx   = '0;
          state_nx = RUN;
        end else begin
          gap_nx = gap_cnt + 8'd1;
        end
      end

      RUN: begin
        go_nx  = 1'b1;
        run_nx = run_cnt + 8'd1;
        if (!bus.fast_busy) begin
          state_nx = EVAL;
          if (iter_q != 8'hFF) begin
            iter_nx = iter_q + 8'd1;
          end
        end else if (run_cnt + 8'd1 == TIMEOUT) begin
          go_nx    = 1'b0;
          terr_nx  = 1'b1;
          conv_nx  = 1'b0;
          state_nx = ERR;
        end
      end

      // Re-arm preloads the gap count with 1: go_fast was high in EVAL, so the
      // low gap between launches is exactly GAP cycles (from IDLE it is GAP+1).
      EVAL: begin
        go_nx = 1'b1;
        if (bus.converged) begin
          go_nx    = 1'b0;
          conv_nx  = 1'b1;
          state_nx = FIN;
        end else if (iter_q == MAX_ITER) begin
          go_nx    = 1'b0;
          conv_nx  = 1'b0;
          state_nx = FIN;
        end else begin
          go_nx    = 1'b0;
          gap_nx   = 8'd1;
          state_nx = ARM;
        end
      end

      FIN, ERR: begin
        go_nx    = 1'b0;
        state_nx = IDLE;
      end

      default: begin
        go_nx    = 1'b0;
        state_nx = IDLE;
      end
    endcase

    done_nx  = (state_nx == FIN) || (state_nx == ERR);
    sbusy_nx = (state_nx == ARM) || (state_nx == RUN) || (state_nx == EVAL);
  end

  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      state   <= IDLE;
      gap_cnt <= '0;
      run_cnt <= '0;
      iter_q  <= '0;
      go_q    <= 1'b0;
      sbusy_q <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
      run_cnt <= run_nx;
      iter_q  <= iter_nx;
      go_q    <= go_nx;
      sbusy_q <= sbusy_nx;
      done_q  <= done_nx;
      conv_q  <= conv_nx;
      terr_q  <= terr_nx;
    end
  end

  assign bus.go_fast     = go_q;
  assign bus.iter_cnt    = iter_q;
  assign bus.seq_busy    = sbusy_q;
  assign bus.done        = done_q;
  assign bus.conv_ok     = conv_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_fast_iter_sequencer.sv
// Bench for fast_iter_sequencer: per-run event timeline predicted from launch/gap/timeout
// arithmetic, compared every cycle against the packed output vector.
module tb_fast_iter_sequencer;
  localparam logic [7:0] P_GAP = 8'd2;
  localparam logic [7:0] P_MAX = 8'd4;
  localparam logic [7:0] P_TO  = 8'd200;
  localparam int GAPI = 2;
  localparam int MAXI = 4;
  localparam int TOI  = 200;

  logic clk_fast = 1'b0;
  logic rst_fast = 1'b1;

  fast_iter_sequencer_if bus ();

  fast_iter_sequencer #(.GAP(P_GAP), .MAX_ITER(P_MAX), .TIMEOUT(P_TO)) dut (
    .clk_fast (clk_fast),
    .rst_fast (rst_fast),
    .bus      (bus)
  );

  always #5 clk_fast = ~clk_fast;

  int total = 0;
  int bad   = 0;

  // per-iteration controller behaviour: busy length after launch, convergence at EVAL
  int lens  [1:MAXI];
  bit convs [1:MAXI];

  // vector layout: {go_fast, seq_busy, done, conv_ok, timeout_err, iter_cnt[7:0]}
  logic [12:0] exp_v    [0:2047];
  int          busy_drv [0:2047];
  int          conv_drv [0:2047];
  int          last_k;
  int          done_at;

  function automatic logic [12:0] obs();
    return {bus.go_fast, bus.seq_busy, bus.done, bus.conv_ok, bus.timeout_err, bus.iter_cnt};
  endfunction

  task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Timeline relative to the start edge (k=0): launch i rises at rise[i], controller
  // finishes after lens[i] cycles, EVAL decides one edge later; timeouts end the run.
  task automatic build_model();
    int  rise [1:MAXI];
    int  fall [1:MAXI];
    int  evl  [1:MAXI];
    int  n_launch, n_eval, t, d, cnt;
    bit  exp_conv, exp_terr, go;
    t = GAPI + 1; n_launch = 0; n_eval = 0; exp_conv = 0; exp_terr = 0; done_at = 0;
    for (int i = 1; i <= MAXI; i++) begin
      n_launch = i;
      rise[i]  = t;
      if (lens[i] > TOI) begin
        fall[i] = t + TOI; done_at = fall[i]; exp_terr = 1;
        break;
      end
      evl[i] = t + lens[i]; n_eval = i; d = evl[i] + 1; fall[i] = d;
      if (convs[i]) begin exp_conv = 1; done_at = d; break; end
      if (i == MAXI) begin done_at = d; break; end
      t = d + GAPI;
    end
    last_k = done_at + 3;
    for (int k = 0; k <= last_k; k++) begin
      cnt = 0; go = 0;
      for (int j = 1; j <= n_eval; j++) if (evl[j] <= k) cnt++;
      for (int j = 1; j <= n_launch; j++) if (k >= rise[j] && k < fall[j]) go = 1;
      exp_v[k] = {go, k < done_at, k == done_at, (k >= done_at) && exp_conv,
                  (k >= done_at) && exp_terr, 8'(cnt)};
      busy_drv[k] = 2;
      conv_drv[k] = 2;
    end
    for (int j = 1; j <= n_launch; j++) begin
      if (j > n_eval) begin
        for (int k = rise[j]; k < rise[j] + TOI; k++) busy_drv[k] = 1;
      end else begin
        for (int k = rise[j]; k <= evl[j] - 2; k++) busy_drv[k] = 1;
        busy_drv[evl[j] - 1] = 0;
        conv_drv[evl[j]]     = convs[j] ? 1 : 0;
      end
    end
  endtask

  task automatic run_case(input string name, input bit inj);
    build_model();
    @(negedge clk_fast);
    bus.start     = 1'b1;
    bus.fast_busy = 1'($urandom_range(0, 1));
    bus.converged = 1'($urandom_range(0, 1));
    @(posedge clk_fast);
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk_fast);
      check($sformatf("%s k=%0d", name, k), obs(), exp_v[k]);
      bus.start     = (inj && k <= done_at) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.fast_busy = (busy_drv[k] == 2) ? 1'($urandom_range(0, 1)) : (busy_drv[k] == 1);
      bus.converged = (conv_drv[k] == 2) ? 1'($urandom_range(0, 1)) : (conv_drv[k] == 1);
    end
  endtask

  task automatic set_all(input int len, input bit conv);
    for (int i = 1; i <= MAXI; i++) begin lens[i] = len; convs[i] = conv; end
  endtask

  initial begin
    bus.start = 1'b0; bus.fast_busy = 1'b1; bus.converged = 1'b0;
    repeat (3) @(negedge clk_fast);
    check("reset_hold", obs(), '0);
    rst_fast = 1'b0;
    repeat (4) begin
      @(negedge clk_fast);
      check("idle_after_reset", obs(), '0);
    end

    // abort mid-RUN: go_fast must fall before the next clock edge, no done afterwards
    bus.start = 1'b1;
    @(negedge clk_fast);
    bus.start = 1'b0;
    repeat (GAPI + 10) @(negedge clk_fast);
    check("abort_pre_running", 13'(bus.go_fast), 13'd1);
    #2 rst_fast = 1'b1;
    #1 check("abort_async", obs(), '0);
    repeat (3) begin
      @(negedge clk_fast);
      check("abort_hold", obs(), '0);
    end
    rst_fast = 1'b0;
    repeat (5) begin
      @(negedge clk_fast);
      check("abort_idle", obs(), '0);
    end

    set_all(10, 0); lens[1] = 133; convs[1] = 1;
    run_case("single", 0);

    set_all(1, 0);
    for (int i = 1; i <= MAXI; i++) lens[i] = $urandom_range(1, 60);
    run_case("limit", 0);

    set_all(255, 0);
    run_case("timeout", 0);

    set_all(TOI, 1);
    run_case("len_eq_timeout", 0);

    set_all(5, 0); lens[1] = 7; lens[2] = TOI + 1;
    run_case("timeout_second", 0);

    set_all(1, 0);
    run_case("len_one_limit", 0);

    set_all(1, 0);
    for (int i = 1; i <= MAXI; i++) lens[i] = $urandom_range(1, 40);
    convs[3] = 1;
    run_case("start_while_busy", 1);

    set_all(1, 0);
    for (int i = 1; i <= MAXI; i++) lens[i] = $urandom_range(1, 30);
    convs[MAXI] = 1;
    run_case("tie", 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 1; i <= MAXI; i++) begin
        lens[i]  = ($urandom_range(0, 9) == 0) ? $urandom_range(TOI + 1, 255)
                                               : $urandom_range(1, TOI);
        convs[i] = ($urandom_range(0, 3) == 0);
      end
      run_case($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fast_iter_sequencer.md
FAST_ITER_SEQUENCER -- requirements
Module: fast_iter_sequencer

Interface
REQ-001 SHALL have parameter GAP, default 8'd2, the number of cycles go_fast is held low before each launch (legal range 1..255).
REQ-002 SHALL have parameter MAX_ITER, default 8'd32, the iteration limit (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 8'd200, the maximum RUN cycles while waiting for fast_busy low (legal range 1..255).
REQ-004 SHALL have one clock, one reset: reset is asynchronous and active-high.
REQ-005 clk_fast  in  1  sole clock, rising edge.
REQ-006 rst_fast  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request to begin a run; sampled only in IDLE.
REQ-008 fast_busy  in  1  busy flag from the fast controller.
REQ-009 converged  in  1  convergence flag; sampled only in EVAL.
REQ-010 go_fast  out  1  registered; low holds the fast controller in reset, high lets it run.
REQ-011 iter_cnt  out  8  iterations completed in the current run.
REQ-012 seq_busy  out  1  high in ARM, RUN and EVAL.
REQ-013 done  out  1  one-cycle pulse at the end of a run.
REQ-014 conv_ok  out  1  final result: high = converged, low = limit hit or error; valid from the done pulse until the next accepted start.
REQ-015 timeout_err  out  1  sticky; set on timeout.

Function
REQ-016 SHALL implement the states IDLE, ARM, RUN, EVAL, FIN and ERR.
REQ-017 IDLE: go_fast=0; on start=1 SHALL clear iter_cnt, conv_ok and timeout_err, then enter ARM.
REQ-018 ARM: go_fast=0 for exactly GAP cycles, then enter RUN.
- go_fast SHALL rise at edge N+GAP+1, where N is the start edge.
REQ-019 RUN: go_fast=1 and the run counter increments every cycle.
- fast_busy=0 SHALL enter EVAL and increment iter_cnt (saturates at 255).
REQ-020 RUN timeout: if the run counter reaches TIMEOUT with fast_busy still 1, the block SHALL enter ERR.
- On the same edge it SHALL set timeout_err and drop go_fast.
REQ-021 EVAL: go_fast=1 (held) and a single-cycle decision, in this priority order:
- converged=1 -> FIN with conv_ok=1;
- else iter_cnt==MAX_ITER -> FIN with conv_ok=0;
- else -> ARM.
REQ-022 FIN: go_fast=0, done=1 for one cycle, then IDLE.
REQ-023 ERR: go_fast=0, done=1 for one cycle, conv_ok=0, then IDLE.
- timeout_err SHALL persist until the next accepted start or rst_fast.
REQ-024 A start while seq_busy=1, in FIN or in ERR SHALL be ignored and SHALL NOT be queued.
REQ-025 fast_busy SHALL be ignored outside RUN.
- The controller reports busy=1 while held in reset, which the sequencer must not treat as a run in progress.
REQ-026 The run counter SHALL clear on every entry to RUN.
REQ-027 Simultaneous converged=1 and iter_cnt==MAX_ITER in EVAL SHALL resolve as converged (conv_ok=1).
REQ-028 All outputs SHALL be registered, and all state transitions SHALL occur on the rising edge of clk_fast.
REQ-029 Unreachable state encodings SHALL return to IDLE on the next edge, with go_fast=0.

Reset
REQ-030 While rst_fast=1, the block SHALL hold: state IDLE, go_fast=0, iter_cnt=0, seq_busy=0, done=0, conv_ok=0, timeout_err=0, run counter=0.
REQ-031 A rst_fast assertion in any state, including mid-RUN, SHALL drive go_fast low immediately (asynchronously).
- No done pulse SHALL be issued for the aborted run.
REQ-032 After rst_fast deasserts, the block SHALL remain in IDLE until a start is sampled.

Verification
REQ-033 Reset: assert rst_fast mid-RUN -> go_fast=0 in the same cycle, all outputs at their reset values, done never pulses.
REQ-034 Single pass (GAP=2, controller model drops busy after 133 cycles, converged=1): start pulse -> go_fast low 2 cycles then high.
- Expected: EVAL after 133 cycles, iter_cnt=1, conv_ok=1, done pulses once.
REQ-035 Limit (MAX_ITER=4, converged=0): expect 4 launches, each preceded by 2 low cycles of go_fast.
- Expected: iter_cnt=4, conv_ok=0, a single done pulse.
REQ-036 Timeout (TIMEOUT=200, busy stuck at 1): go_fast drops after 200 RUN cycles.
- Expected: timeout_err=1, done pulse, conv_ok=0; the next start clears timeout_err.
REQ-037 Start during busy: start pulses in ARM/RUN/EVAL -> no restart, iter_cnt unchanged.
REQ-038 Tie: converged=1 at iter_cnt==MAX_ITER -> conv_ok=1.
